ysyx_bus_arb: RTL and testbench

Two-master, one-slave memory bus arbiter. It sits between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write) on one side, and a single AXI4-Lite-style memory/SoC port on the other. It grants one transaction at a time, registers the address, data and strobe at grant, sequences the AR/R or AW/W/B phases, and routes the response back to the owner. Exactly one transaction is outstanding at any time.

---
 rtl/ysyx_bus_arb_pkg.sv | 19 +
 rtl/ysyx_bus_arb_rr2.sv | 27 ++
 rtl/ysyx_bus_arb.sv | 158 +++++++++++++++
 tb/tb_ysyx_bus_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_bus_arb_pkg.sv
// Shared encodings for the two-master bus arbiter: FSM states, owner ids
// and AXI response codes.
package ysyx_bus_arb_pkg;

    typedef enum logic [2:0] {
        ysyx_ARB_IDLE    = 3'd0,
        ysyx_ARB_RD_ADDR = 3'd1,
        ysyx_ARB_RD_DATA = 3'd2,
        ysyx_ARB_WR_REQ  = 3'd3,
        ysyx_ARB_WR_RESP = 3'd4
    } arb_state_t;

    localparam logic ysyx_ARB_OWN_IFU = 1'b0;
    localparam logic ysyx_ARB_OWN_LSU = 1'b1;

    localparam logic [1:0] ysyx_RESP_OKAY   = 2'b00;
    localparam logic [1:0] ysyx_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_bus_arb_rr2.sv
// Two-way round-robin picker: req[0]=IFU, req[1]=LSU. On a tie the side
// that did not win last time is granted. Purely combinational.
module ysyx_rr_arb2
    import ysyx_bus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       last_nxt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == ysyx_ARB_OWN_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        last_nxt = last;
        if (gnt[0])
            last_nxt = ysyx_ARB_OWN_IFU;
        else if (gnt[1])
            last_nxt = ysyx_ARB_OWN_LSU;
    end

endmodule

// File: rtl/ysyx_bus_arb.sv
// IFU/LSU to single AXI4-Lite port arbiter. One transaction outstanding;
// request is latched at grant and the bus phases are sequenced by the FSM.
module ysyx_bus_arb
    import ysyx_bus_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    output logic              lsu_wready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic              bus_err
);

    arb_state_t        state, state_nxt;
    logic              owner_q, last_q, last_nxt;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [7:0]        rstrb_q;
    logic              aw_done, w_done;
    logic              grant;

    ysyx_rr_arb2 u_rr (
        .req      ({lsu_awvalid | lsu_arvalid, ifu_arvalid}),
        .last     (last_q),
        .gnt      (gnt),
        .last_nxt (last_nxt)
    );

    assign grant = (state == ysyx_ARB_IDLE) && (gnt != 2'b00);

    always_comb begin
        state_nxt  = state;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        ifu_rvalid = 1'b0;
        lsu_rvalid = 1'b0;
        lsu_wready = 1'b0;
        bus_err    = 1'b0;
        case (state)
            ysyx_ARB_IDLE: begin
                // A simultaneous LSU write and read resolves to the write.
                if (gnt[0])
                    state_nxt = ysyx_ARB_RD_ADDR;
                else if (gnt[1])
                    state_nxt = lsu_awvalid ? ysyx_ARB_WR_REQ : ysyx_ARB_RD_ADDR;
            end
            ysyx_ARB_RD_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready)
                    state_nxt = ysyx_ARB_RD_DATA;
            end
            ysyx_ARB_RD_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    ifu_rvalid = (owner_q == ysyx_ARB_OWN_IFU);
                    lsu_rvalid = (owner_q == ysyx_ARB_OWN_LSU);
                    bus_err    = (m_rresp != ysyx_RESP_OKAY);
                    state_nxt  = ysyx_ARB_IDLE;
                end
            end
            ysyx_ARB_WR_REQ: begin
                m_awvalid = !aw_done;
                m_wvalid  = !w_done;
                if ((aw_done || m_awready) && (w_done || m_wready))
                    state_nxt = ysyx_ARB_WR_RESP;
            end
            ysyx_ARB_WR_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    lsu_wready = 1'b1;
                    bus_err    = (m_bresp != ysyx_RESP_OKAY);
                    state_nxt  = ysyx_ARB_IDLE;
                end
            end
            default: state_nxt = ysyx_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ysyx_ARB_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= ysyx_ARB_OWN_IFU;
            last_q  <= ysyx_ARB_OWN_LSU;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (grant) begin
            owner_q <= gnt[1] ? ysyx_ARB_OWN_LSU : ysyx_ARB_OWN_IFU;
            last_q  <= last_nxt;
            addr_q  <= gnt[0] ? ifu_araddr : (lsu_awvalid ? lsu_awaddr : lsu_araddr);
            wdata_q <= lsu_wdata;
            wstrb_q <= lsu_wstrb[3:0];
            rstrb_q <= lsu_rstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == ysyx_ARB_WR_REQ) begin
            if (m_awvalid && m_awready) aw_done <= 1'b1;
            if (m_wvalid && m_wready)   w_done  <= 1'b1;
        end
    end

    assign ifu_rdata = m_rdata;
    assign lsu_rdata = m_rdata;
    assign m_araddr  = addr_q;
    assign m_awaddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;

    // Read strobe is kept for debug visibility only; upper write strobes are ignored.
    logic unused_bits;
    assign unused_bits = ^{rstrb_q, lsu_wstrb[7:4]};

endmodule

// File: tb/tb_ysyx_bus_arb.sv
// Bench for ysyx_bus_arb: latency-programmable bus slave, scoreboard of
// expected bus transactions, table-driven arbitration vectors.
module tb_ysyx_bus_arb;

    localparam logic [1:0] K_IFU = 2'd0, K_LR = 2'd1, K_LW = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  resp;
    } tx_t;

    typedef struct {
        logic        iv, lr, lw;
        logic [31:0] ia, ra, wa, wd;
        logic [7:0]  ws;
        logic [1:0]  rresp, bresp;
        int          lat;
        int          n;
        logic [2:0][1:0] ord;
    } vec_t;

    logic        clk, rst;
    logic [31:0] ifu_araddr, ifu_rdata, lsu_araddr, lsu_rdata, lsu_awaddr, lsu_wdata;
    logic        ifu_arvalid, ifu_rvalid, lsu_arvalid, lsu_rvalid, lsu_awvalid, lsu_wready;
    logic [7:0]  lsu_rstrb, lsu_wstrb;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
    logic        m_wvalid, m_wready, m_bvalid, m_bready, bus_err;
    logic [1:0]  m_rresp, m_bresp;
    logic [3:0]  m_wstrb;

    int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic       force_rv = 1'b0;
    logic [1:0] rresp_k = 2'b00, bresp_k = 2'b00;

    int   n_chk = 0, n_fail = 0;
    tx_t  exp_q[$];
    tx_t  cur;
    vec_t vecs[8];

    ysyx_bus_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: each ready/valid fires after its programmed wait count.
    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a ^ 32'h5EAD_BEEF;
    endfunction

    assign m_rdata   = rd_of(m_araddr);
    assign m_rresp   = rresp_k;
    assign m_bresp   = bresp_k;
    assign m_arready = m_arvalid && (ar_cnt >= ar_lat);
    assign m_rvalid  = force_rv || (m_rready && (r_cnt >= r_lat));
    assign m_awready = m_awvalid && (aw_cnt >= aw_lat);
    assign m_wready  = m_wvalid && (w_cnt >= w_lat);
    assign m_bvalid  = m_bready && (b_cnt >= b_lat);

    always @(posedge clk) begin
        ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
        r_cnt  <= (m_rready && !m_rvalid)   ? r_cnt + 1  : 0;
        aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
        w_cnt  <= (m_wvalid && !m_wready)   ? w_cnt + 1  : 0;
        b_cnt  <= (m_bready && !m_bvalid)   ? b_cnt + 1  : 0;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        if (m_arvalid && m_arready) begin
            if (exp_q.size() == 0) check("ar_unexpected", 64'(1), 64'(0));
            else begin
                cur = exp_q.pop_front();
                check("ar_is_read", 64'(cur.kind == K_LW), 64'(0));
                check("ar_addr", 64'(m_araddr), 64'(cur.addr));
            end
        end
        if (m_awvalid && m_awready) begin
            if (exp_q.size() == 0) check("aw_unexpected", 64'(1), 64'(0));
            else begin
                cur = exp_q.pop_front();
                check("aw_is_write", 64'(cur.kind == K_LW), 64'(1));
                check("aw_addr", 64'(m_awaddr), 64'(cur.addr));
                check("w_data", 64'(m_wdata), 64'(cur.wdata));
                check("w_strb", 64'(m_wstrb), 64'(cur.wstrb));
            end
        end
        if (m_rvalid && m_rready) begin
            check("r_ifu_rvalid", 64'(ifu_rvalid), 64'(cur.kind == K_IFU));
            check("r_lsu_rvalid", 64'(lsu_rvalid), 64'(cur.kind == K_LR));
            check("r_rdata", 64'(cur.kind == K_IFU ? ifu_rdata : lsu_rdata), 64'(rd_of(cur.addr)));
            check("r_bus_err", 64'(bus_err), 64'(cur.resp != 2'b00));
        end else if (m_bvalid && m_bready) begin
            check("b_pulses", 64'({lsu_wready, ifu_rvalid, lsu_rvalid}), 64'(3'b100));
            check("b_bus_err", 64'(bus_err), 64'(cur.resp != 2'b00));
        end else begin
            check("idle_pulses", 64'({bus_err, ifu_rvalid, lsu_rvalid, lsu_wready}), 64'(0));
        end
    endtask

    task automatic at_sample();
        @(negedge clk);
        monitor();
    endtask

    // Masters drop their request in the IDLE cycle following their response.
    task automatic advance();
        logic di, dr, dw;
        di = ifu_rvalid; dr = lsu_rvalid; dw = lsu_wready;
        @(posedge clk); #1;
        if (di) ifu_arvalid = 1'b0;
        if (dr) lsu_arvalid = 1'b0;
        if (dw) lsu_awvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_awvalid = 1'b0;
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] r);
        tx_t t;
        t.kind = k; t.addr = a; t.wdata = d; t.wstrb = s; t.resp = r;
        exp_q.push_back(t);
    endtask

    task automatic run_idle(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || ifu_arvalid || lsu_arvalid || lsu_awvalid) && c < budget) begin
            at_sample();
            advance();
            c++;
        end
        if (c >= budget) begin
            check("timeout", 64'(1), 64'(0));
            ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_awvalid = 1'b0;
            exp_q.delete();
        end
    endtask

    function automatic vec_t mk(input logic iv, lr, lw, input logic [31:0] ia, ra, wa, wd,
                                input logic [7:0] ws, input logic [1:0] rr, br,
                                input int lat, n, input logic [1:0] o0, o1, o2);
        vec_t v;
        v.iv = iv; v.lr = lr; v.lw = lw; v.ia = ia; v.ra = ra; v.wa = wa; v.wd = wd;
        v.ws = ws; v.rresp = rr; v.bresp = br; v.lat = lat; v.n = n;
        v.ord[0] = o0; v.ord[1] = o1; v.ord[2] = o2;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [1:0] k;
        ar_lat = v.lat; r_lat = v.lat; aw_lat = v.lat; w_lat = v.lat + 1; b_lat = v.lat;
        rresp_k = v.rresp; bresp_k = v.bresp;
        for (int j = 0; j < v.n; j++) begin
            k = v.ord[j];
            push(k, (k == K_IFU) ? v.ia : (k == K_LR) ? v.ra : v.wa, v.wd, v.ws[3:0],
                 (k == K_LW) ? v.bresp : v.rresp);
        end
        ifu_araddr = v.ia; lsu_araddr = v.ra; lsu_awaddr = v.wa;
        lsu_wdata = v.wd; lsu_wstrb = v.ws;
        ifu_arvalid = v.iv; lsu_arvalid = v.lr; lsu_awvalid = v.lw;
        run_idle(300);
    endtask

    initial begin
        rst = 1'b1;
        ifu_araddr = '0; lsu_araddr = '0; lsu_awaddr = '0; lsu_wdata = '0;
        lsu_wstrb = '0; lsu_rstrb = 8'h0F;
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_awvalid = 1'b0;

        // Expected grant order computed by hand; round-robin restarts with IFU priority.
        vecs[0] = mk(1, 1, 0, 32'h100, 32'h200, 0, 0, 8'h00, 2'b00, 2'b00, 0, 2, K_IFU, K_LR, K_IFU);
        vecs[1] = mk(1, 1, 0, 32'h100, 32'h200, 0, 0, 8'h00, 2'b00, 2'b00, 1, 2, K_IFU, K_LR, K_IFU);
        vecs[2] = mk(1, 1, 0, 32'h100, 32'h200, 0, 0, 8'h00, 2'b00, 2'b00, 2, 2, K_IFU, K_LR, K_IFU);
        vecs[3] = mk(0, 0, 1, 0, 0, 32'h8000_0010, 32'h1234_5678, 8'hFF, 2'b00, 2'b00, 1, 1, K_LW, K_LW, K_LW);
        vecs[4] = mk(0, 1, 1, 0, 32'h304, 32'h300, 32'hCAFE_F00D, 8'h01, 2'b00, 2'b00, 0, 2, K_LW, K_LR, K_LR);
        vecs[5] = mk(0, 1, 0, 0, 32'h400, 0, 0, 8'h00, 2'b10, 2'b00, 0, 1, K_LR, K_LR, K_LR);
        vecs[6] = mk(1, 0, 1, 32'h500, 0, 32'h600, 32'hA5A5_A5A5, 8'h0C, 2'b00, 2'b10, 1, 2, K_IFU, K_LW, K_LW);
        vecs[7] = mk(1, 1, 1, 32'h700, 32'h704, 32'h708, 32'h0BAD_F00D, 8'hF3, 2'b00, 2'b00, 0, 3, K_IFU, K_LW, K_LR);

        do_reset();
        at_sample();
        check("rst_ctrl", 64'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
                               ifu_rvalid, lsu_rvalid, lsu_wready, bus_err}), 64'(0));
        check("rst_addr", 64'(m_araddr), 64'(0));
        check("rst_wdata", 64'({m_wdata, m_wstrb}), 64'(0));
        advance();

        // Single IFU read, zero-wait slave: AR in cycle 1, response in cycle 2.
        push(K_IFU, 32'h8000_0000, 0, 0, 2'b00);
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            at_sample();
            case (c)
                0: check("t1_c0_arvalid", 64'(m_arvalid), 64'(0));
                1: begin
                    check("t1_c1_arvalid", 64'(m_arvalid), 64'(1));
                    check("t1_c1_araddr", 64'(m_araddr), 64'h8000_0000);
                end
                default: begin
                    check("t1_c2_ifu_rvalid", 64'(ifu_rvalid), 64'(1));
                    check("t1_c2_ifu_rdata", 64'(ifu_rdata), 64'hDEAD_BEEF);
                    check("t1_c2_lsu_rvalid", 64'(lsu_rvalid), 64'(0));
                end
            endcase
            advance();
        end
        run_idle(20);

        do_reset();
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // LSU store: awready immediate, wready 2 cycles later, bvalid 1 cycle into WR_RESP.
        ar_lat = 0; r_lat = 0; aw_lat = 0; w_lat = 2; b_lat = 1;
        rresp_k = 2'b00; bresp_k = 2'b00;
        push(K_LW, 32'h8000_0010, 32'h1234_5678, 4'hF, 2'b00);
        lsu_awaddr = 32'h8000_0010; lsu_wdata = 32'h1234_5678; lsu_wstrb = 8'h0F;
        lsu_awvalid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            at_sample();
            case (c)
                0: check("w_c0_awvalid", 64'(m_awvalid), 64'(0));
                1: check("w_c1_aw_w", 64'({m_awvalid, m_wvalid}), 64'(2'b11));
                2: check("w_c2_aw_w", 64'({m_awvalid, m_wvalid}), 64'(2'b01));
                3: check("w_c3_aw_w", 64'({m_awvalid, m_wvalid}), 64'(2'b01));
                4: check("w_c4_w_b_wr", 64'({m_wvalid, m_bready, lsu_wready}), 64'(3'b010));
                5: check("w_c5_wready", 64'(lsu_wready), 64'(1));
                default: check("w_c6_b_wr", 64'({m_bready, lsu_wready}), 64'(0));
            endcase
            advance();
        end
        run_idle(20);

        // Reset in RD_DATA with the slave stalled; a late rvalid must not leak upstream.
        ar_lat = 0; r_lat = 1000;
        push(K_LR, 32'h700, 0, 0, 2'b00);
        lsu_araddr = 32'h700; lsu_arvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            at_sample();
            case (c)
                0: ;
                1: check("rr_c1_arvalid", 64'(m_arvalid), 64'(1));
                2: check("rr_c2_rready", 64'(m_rready), 64'(1));
                3: check("rr_c3_rready", 64'(m_rready), 64'(1));
                default: begin
                    check("rr_c4_valids", 64'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 64'(0));
                    check("rr_c4_upstream", 64'({ifu_rvalid, lsu_rvalid, lsu_wready, bus_err}), 64'(0));
                end
            endcase
            advance();
            if (c == 2) begin rst = 1'b1; lsu_arvalid = 1'b0; end
            if (c == 3) begin rst = 1'b0; force_rv = 1'b1; end
            if (c == 4) force_rv = 1'b0;
        end
        r_lat = 0;
        exp_q.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
